// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencing for the 5-stage pipeline.
// Handles load-use interlock, taken-branch flush and data-memory freeze with timeout.
// Enable/flush outputs are combinational from state and inputs; counters and timeout flag are registered.
module hazard_stall_controller #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             mem_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ctrl_stall,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WAIT_W = 8;

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_MEM_WAIT = 2'd1;
   localparam logic [1:0] S_ERROR    = 2'd2;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic freeze;
   logic load_use;

   // Memory not ready freezes everything; a load feeding the ID instruction needs one bubble.
   assign freeze   = dmem_req & ~dmem_ready;
   assign load_use = id_valid & ex_memread & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

   // Prioritised pipeline enables/flushes plus next-state, timeout and counter updates.
   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      idex_write    = 1'b1;
      exmem_write   = 1'b1;
      ctrl_stall    = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      flush_exmem   = 1'b0;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;

      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         ctrl_stall  = 1'b1;
      end else if (state_q == S_ERROR || freeze) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
      end else if (mem_branch_taken) begin
         // Any load-use stall is on the wrong path, so the flush wins.
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ctrl_stall = 1'b1;
      end

      case (state_q)
         S_RUN: begin
            if (freeze) begin
               state_d    = S_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         S_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = S_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
               state_d       = S_ERROR;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d    = S_RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (state_q != S_ERROR) begin
         if ((ctrl_stall || freeze) && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (flush_ifid && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // State, wait counter, sticky timeout and performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (default and small parameters) share one stimulus.
module tb_hazard_stall_controller;

   localparam int unsigned MAX0 = 15;
   localparam int unsigned W0   = 16;
   localparam int unsigned MAX1 = 4;
   localparam int unsigned W1   = 3;

   logic       clk;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs2;
   logic [4:0] ex_rd;
   logic       ex_memread;
   logic       mem_branch_taken;
   logic       dmem_req;
   logic       dmem_ready;

   // Output vectors: {pc, ifid, idex, exmem, ctrl_stall, flush_ifid, flush_idex, flush_exmem}
   wire [7:0]    o0;
   wire [7:0]    o1;
   wire          mt0;
   wire          mt1;
   wire [W0-1:0] sc0;
   wire [W0-1:0] fc0;
   wire [W1-1:0] sc1;
   wire [W1-1:0] fc1;

   int n_checks;
   int n_errors;

   // Behavioural model state per instance
   int m_streak[2];
   bit m_err[2];
   int m_stall[2];
   int m_flush[2];
   int m_max[2];
   int m_cap[2];

   hazard_stall_controller #(.MEM_WAIT_MAX(MAX0), .CNT_W(W0)) dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
      .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(o0[7]), .ifid_write(o0[6]), .idex_write(o0[5]), .exmem_write(o0[4]),
      .ctrl_stall(o0[3]), .flush_ifid(o0[2]), .flush_idex(o0[1]), .flush_exmem(o0[0]),
      .mem_timeout(mt0), .stall_count(sc0), .flush_count(fc0)
   );

   hazard_stall_controller #(.MEM_WAIT_MAX(MAX1), .CNT_W(W1)) dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
      .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(o1[7]), .ifid_write(o1[6]), .idex_write(o1[5]), .exmem_write(o1[4]),
      .ctrl_stall(o1[3]), .flush_ifid(o1[2]), .flush_idex(o1[1]), .flush_exmem(o1[0]),
      .mem_timeout(mt1), .stall_count(sc1), .flush_count(fc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected enables/flushes straight from the priority rules
   function automatic logic [7:0] exp_out(input bit err);
      bit fz;
      bit lu;
      fz = dmem_req && !dmem_ready;
      lu = id_valid && ex_memread && (ex_rd != 0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
      if (reset)                 return 8'h08;
      else if (err || fz)        return 8'h00;
      else if (mem_branch_taken) return 8'hF7;
      else if (lu)               return 8'h38;
      else                       return 8'hF0;
   endfunction

   // Model update: a streak of freeze cycles longer than the limit means timeout
   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_streak[i] = 0;
            m_err[i]    = 0;
            m_stall[i]  = 0;
            m_flush[i]  = 0;
         end else if (!m_err[i]) begin
            logic [7:0] e;
            bit fz;
            e  = exp_out(1'b0);
            fz = dmem_req && !dmem_ready;
            if ((e[3] || fz) && m_stall[i] < m_cap[i]) m_stall[i] = m_stall[i] + 1;
            if (e[2] && m_flush[i] < m_cap[i])         m_flush[i] = m_flush[i] + 1;
            if (fz) begin
               m_streak[i] = m_streak[i] + 1;
               if (m_streak[i] > m_max[i]) m_err[i] = 1;
            end else begin
               m_streak[i] = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      check("out0", int'(o0), int'(exp_out(m_err[0])));
      check("out1", int'(o1), int'(exp_out(m_err[1])));
      check("timeout0", int'(mt0), int'(m_err[0]));
      check("timeout1", int'(mt1), int'(m_err[1]));
      check("stall_cnt0", int'(sc0), m_stall[0]);
      check("stall_cnt1", int'(sc1), m_stall[1]);
      check("flush_cnt0", int'(fc0), m_flush[0]);
      check("flush_cnt1", int'(fc1), m_flush[1]);
   end

   // Apply one cycle of inputs and land on that cycle's falling edge
   task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br,
                         input logic rq, input logic rdy);
      @(posedge clk);
      #1;
      id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2;
      ex_rd = rd; ex_memread = mr; mem_branch_taken = br;
      dmem_req = rq; dmem_ready = rdy;
      @(negedge clk);
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_max[0] = MAX0;  m_cap[0] = (1 << W0) - 1;
      m_max[1] = MAX1;  m_cap[1] = (1 << W1) - 1;
      reset = 1'b1;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0;
      ex_memread = 0; mem_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
      repeat (2) @(negedge clk);
      check("reset_out", int'(o0), 32'h08);
      check("reset_cnt", int'(sc0), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      idle();
      // ld x5 in EX, add using x5 in ID
      set_in(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lu_out", int'(o0), 32'h38);
      check("lu_cnt_before", int'(sc0), 0);
      set_in(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lu_release", int'(o0), 32'hF0);
      check("lu_cnt_after", int'(sc0), 1);
      // x0 destination, rs2 not used, ID invalid: none stall
      set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("x0_nostall", int'(o0[3]), 0);
      set_in(1'b1, 5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rs2_unused_nostall", int'(o0[3]), 0);
      set_in(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      check("invalid_nostall", int'(o0[3]), 0);
      check("nostall_cnt", int'(sc0), 1);
      // Taken branch beats load-use
      set_in(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      check("br_over_lu", int'(o0), 32'hF7);
      idle();
      check("br_flush_cnt", int'(fc0), 1);
      check("br_stall_cnt", int'(sc0), 1);
      // Three freeze cycles hold a taken branch, acted on when ready
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
         check("freeze_out", int'(o0), 32'h00);
      end
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("ready_flush", int'(o0), 32'hF7);
      check("freeze_stall_cnt", int'(sc0), 4);
      idle();
      check("freeze_flush_cnt", int'(fc0), 2);
      // Five freeze cycles: small-limit instance times out, default one does not
      for (int k = 0; k < 5; k++) begin
         set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("timeout_set", int'(mt1), 1);
      check("timeout_hold_out", int'(o1), 32'h00);
      check("no_timeout_dflt", int'(mt0), 0);
      check("dflt_resumes", int'(o0), 32'hF0);
      check("sat_cnt_small", int'(sc1), 7);
      idle();
      // Reset pulse clears the sticky timeout at once
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_clears_timeout", int'(mt1), 0);
      check("rst_forced_out", int'(o1), 32'h08);
      check("rst_cnt_clear", int'(sc1), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      // Nine back-to-back load-use cycles
      for (int k = 0; k < 9; k++) begin
         set_in(1'b1, 5'd7, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      idle();
      check("sat_stall_small", int'(sc1), 7);
      check("stall_dflt_9", int'(sc0), 9);
      idle();
      check("sat_stall_hold", int'(sc1), 7);
      // Reset in the middle of a memory wait
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("midwait_rst_out", int'(o0), 32'h08);
      check("midwait_rst_stall", int'(sc0), 0);
      check("midwait_rst_flush", int'(fc0), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle();
      idle();
      check("post_rst_out", int'(o0), 32'hF0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It detects load-use hazards and drives the control unit's Stall input, which bubbles ID/EX. It flushes the wrong-path stages when a branch resolves taken in MEM, and freezes the whole pipeline while data memory is not ready, with a timeout. It also keeps saturating stall and flush performance counters.

Parameters:
MEM_WAIT_MAX, 15, cycles a data-memory access may wait before a timeout is declared (1 to 2^8-1)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  5  rs1 of the instruction in ID
id_rs2  input  5  rs2 of the instruction in ID
id_uses_rs2  input  1  ID instruction reads rs2 (R-type, sd, branch)
ex_rd  input  5  destination of the instruction in EX
ex_memread  input  1  EX instruction is ld
mem_branch_taken  input  1  branch in MEM resolved taken
dmem_req  input  1  MEM stage issues a load or store
dmem_ready  input  1  data memory completes the access this cycle
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID enable
idex_write  output  1  ID/EX enable
exmem_write  output  1  EX/MEM enable
ctrl_stall  output  1  drives Stall of the control unit (zero controls into ID/EX)
flush_ifid  output  1  clear IF/ID to a bubble
flush_idex  output  1  clear ID/EX to a bubble
flush_exmem  output  1  clear EX/MEM to a bubble
mem_timeout  output  1  sticky error flag
stall_count  output  CNT_W  cycles with ctrl_stall or freeze
flush_count  output  CNT_W  cycles with a flush

Behaviour:
- Signals:
  - freeze = dmem_req & ~dmem_ready.
  - load_use = id_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
- Outputs are combinational (Mealy) from state and inputs. Priority is evaluated in the same cycle:
  1. state ERROR: all *_write = 0, ctrl_stall = 0, flushes = 0.
  2. freeze: all *_write = 0, ctrl_stall = 0, flushes = 0. The branch in MEM is held and acted on after ready.
  3. mem_branch_taken: all *_write = 1, flush_ifid = flush_idex = flush_exmem = 1, ctrl_stall = 0. This overrides load_use because the stalled instruction is wrong-path.
  4. load_use: pc_write = 0, ifid_write = 0, idex_write = 1, exmem_write = 1, ctrl_stall = 1. The stall is exactly one cycle, because the load leaves EX next cycle.
  5. else: all *_write = 1, all others 0.
- Output states:
  - The MEM/WB register is never frozen by this block. During freeze, MEM/WB receives a bubble, handled by the datapath.
- State machine (states RUN, MEM_WAIT, ERROR) with an 8-bit wait_cnt:
  - RUN: if freeze, go to MEM_WAIT with wait_cnt = 1.
  - MEM_WAIT:
    - if dmem_ready, go to RUN with wait_cnt = 0. Outputs that cycle follow rules 3 to 5.
    - else if wait_cnt == MEM_WAIT_MAX, go to ERROR and set mem_timeout = 1.
    - else wait_cnt += 1.
  - ERROR: held until reset; mem_timeout stays 1.
- Counters:
  - stall_count += 1 on a cycle with ctrl_stall = 1 or freeze = 1.
  - flush_count += 1 on a cycle with flush_ifid = 1.
  - Both saturate at all-ones and never wrap. They do not count in ERROR.
- Reset (asynchronous, takes effect immediately, including mid-wait):
  - State is RUN, wait_cnt = 0, mem_timeout = 0, stall_count = flush_count = 0.
  - While reset = 1, outputs are forced to: all *_write = 0, ctrl_stall = 1, flushes = 0.
  - The first edge after deassertion evaluates normally.
- Boundary cases:
  - ex_rd = x0 never stalls.
  - id_valid = 0 never stalls.
  - dmem_req with dmem_ready = 1 in the same cycle is no freeze (zero-wait access).

Test Plan:
- ld x5 in EX (ex_memread=1, ex_rd=5), ID add with rs1=5 -> one cycle: pc_write=0, ifid_write=0, ctrl_stall=1, stall_count=1. Next cycle (ex_memread=0) -> all writes 1, ctrl_stall=0.
- Same as above with ex_rd=0, or with rs2=5 and id_uses_rs2=0 -> no stall, stall_count stays 0.
- mem_branch_taken=1 together with load_use=1 -> three flushes=1, pc_write=1, ctrl_stall=0, flush_count=1.
- dmem_req=1 with dmem_ready low for 3 cycles, plus mem_branch_taken=1 -> 3 cycles all writes 0 and no flush, state MEM_WAIT. On the ready cycle, flushes=1 and state returns to RUN. stall_count=3.
- MEM_WAIT_MAX=4, dmem_ready held low -> after 5 freeze cycles, mem_timeout=1 and all writes stay 0 even after dmem_ready=1. Pulse reset -> mem_timeout=0, state RUN.
- CNT_W=3, 9 consecutive load-use cycles -> stall_count=7 and holds. Assert reset during MEM_WAIT -> outputs forced immediately, counters 0.
